// File: rtl/render_frame_buffer_if.sv
// render_frame_buffer_if: renderer write port, display scan port and status outputs of the frame buffer
interface render_frame_buffer_if #(parameter int AW = 12);
    logic          wr_valid_in;
    logic [AW-1:0] wr_addr_in;
    logic [9:0]    wr_color_in;
    logic          wr_ready_out;
    logic          frame_done_in;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic [11:0]   pixel_out;
    logic          swap_out;
    logic          front_sel_out;
    logic          clearing_out;
    modport master (
        output wr_valid_in, wr_addr_in, wr_color_in, frame_done_in, hcount_in, vcount_in,
        input  wr_ready_out, pixel_out, swap_out, front_sel_out, clearing_out
    );
    modport slave (
        input  wr_valid_in, wr_addr_in, wr_color_in, frame_done_in, hcount_in, vcount_in,
        output wr_ready_out, pixel_out, swap_out, front_sel_out, clearing_out
    );
endinterface

// File: rtl/render_frame_buffer.sv
// render_frame_buffer: double-buffered colour store with vblank bank swap, back-bank clear and windowed upscaled display read
module render_frame_buffer #(
    parameter int          SIZE       = 64,
    parameter int          X0         = 224,
    parameter int          Y0         = 352,
    parameter int          SCALE_LOG2 = 0,
    parameter int          H_ACTIVE   = 1024,
    parameter int          V_ACTIVE   = 768,
    parameter logic [11:0] BG_COLOR   = 12'h800
) (
    input logic                  clk,
    input logic                  rst,
    render_frame_buffer_if.slave bus
);
    localparam int AW = $clog2(SIZE * SIZE);
    localparam int LW = $clog2(SIZE);
    localparam int W  = SIZE << SCALE_LOG2;
    localparam logic [AW:0] LAST_A = (AW + 1)'(2 * SIZE * SIZE - 1);
    localparam logic [AW:0] LAST_B = (AW + 1)'(SIZE * SIZE - 1);
    localparam logic [11:0] X_LO = 12'(X0);
    localparam logic [11:0] X_HI = 12'(X0 + W);
    localparam logic [11:0] H_END = 12'(H_ACTIVE);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + W);
    localparam logic [10:0] V_END = 11'(V_ACTIVE);
    typedef enum logic [1:0] {CLEAR_ALL, CLEAR, IDLE} state_t;
    state_t      r_state, w_next;
    logic [AW:0] r_cnt, w_waddr, r_raddr;
    logic [9:0]  w_wdata, r_rdata;
    logic [9:0]  r_mem [2 * SIZE * SIZE];
    logic        w_we, w_vbs, w_swap, w_pend_next;
    logic        r_front, r_pending, r_ready, r_swap;
    logic        r_win1, r_win2, r_act1, r_act2;
    logic [11:0] w_h;
    logic [10:0] w_v;
    logic [LW-1:0] w_row, w_col;
    assign w_h = {1'b0, bus.hcount_in};
    assign w_v = {1'b0, bus.vcount_in};
    assign w_vbs = w_v == V_END && w_h == 12'd0;
    assign w_swap = r_state == IDLE && w_vbs && (r_pending || bus.frame_done_in);
    assign w_pend_next = !w_swap && (r_pending || bus.frame_done_in);
    assign w_row = LW'((w_v - Y_LO) >> SCALE_LOG2);
    assign w_col = LW'((w_h - X_LO) >> SCALE_LOG2);
    always_comb begin
        w_next = (r_state == CLEAR_ALL && r_cnt == LAST_A) || (r_state == CLEAR && r_cnt == LAST_B) ? IDLE :
                 w_swap ? CLEAR : r_state;
        w_we = r_state != IDLE || (bus.wr_valid_in && r_ready);
        w_waddr = r_state == CLEAR_ALL ? r_cnt : {~r_front, r_state == CLEAR ? r_cnt[AW-1:0] : bus.wr_addr_in};
        w_wdata = r_state == IDLE ? bus.wr_color_in : 10'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ALL;
            r_cnt <= '0;
            r_front <= 1'b0;
            r_pending <= 1'b0;
            r_ready <= 1'b0;
            r_swap <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
            r_front <= r_front ^ w_swap;
            r_pending <= w_pend_next;
            r_ready <= w_next == IDLE && !w_pend_next;
            r_swap <= w_swap;
        end
    end
    always_ff @(posedge clk) begin
        if (w_we && !rst) r_mem[w_waddr] <= w_wdata;
        r_rdata <= r_mem[r_raddr];
        r_raddr <= {r_front, w_row, w_col};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_win1, r_win2, r_act1, r_act2} <= '0;
        end else begin
            r_win1 <= w_h >= X_LO && w_h < X_HI && w_v >= Y_LO && w_v < Y_HI;
            r_act1 <= w_h < H_END && w_v < V_END;
            r_win2 <= r_win1;
            r_act2 <= r_act1;
        end
    end
    assign bus.pixel_out = !r_act2 ? 12'h000 :
                           (!r_win2 || r_rdata == 10'd0) ? BG_COLOR :
                           {r_rdata[9:7], 1'b0, r_rdata[6:3], r_rdata[2:0], 1'b0};
    assign bus.wr_ready_out = r_ready;
    assign bus.swap_out = r_swap;
    assign bus.front_sel_out = r_front;
    assign bus.clearing_out = r_state != IDLE;
endmodule

// File: tb/tb_render_frame_buffer.sv
// tb_render_frame_buffer: directed stimulus with a pixel scoreboard checked two cycles after each probe
module tb_render_frame_buffer;
    typedef struct {
        string       nm;
        logic [11:0] v;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       probe = 1'b0;
    logic [1:0] pv = 2'b00;
    int         checks = 0;
    int         errors = 0;
    exp_t       q[$];
    exp_t       e;
    render_frame_buffer_if #(.AW(12)) bus();
    render_frame_buffer #(.SCALE_LOG2(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) pv <= {pv[0], probe};
    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (pv[1]) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel got %h want none", bus.pixel_out);
            end else begin
                e = q.pop_front();
                chk(e.nm, bus.pixel_out, e.v);
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic px(input int h, input int v, input logic [11:0] exp, input string nm);
        exp_t x;
        x.nm = nm;
        x.v = exp;
        q.push_back(x);
        bus.hcount_in = 11'(h);
        bus.vcount_in = 10'(v);
        probe = 1'b1;
        tick(1);
        probe = 1'b0;
        bus.hcount_in = 11'd1100;
        bus.vcount_in = 10'd0;
    endtask
    task automatic wr(input int a, input logic [9:0] c);
        bus.wr_valid_in = 1'b1;
        bus.wr_addr_in = 12'(a);
        bus.wr_color_in = c;
        tick(1);
        bus.wr_valid_in = 1'b0;
    endtask
    task automatic pulse_done();
        bus.frame_done_in = 1'b1;
        tick(1);
        bus.frame_done_in = 1'b0;
    endtask
    task automatic vblank(input logic fd, input logic sw, input logic fr, input string nm);
        bus.frame_done_in = fd;
        bus.vcount_in = 10'd768;
        bus.hcount_in = 11'd0;
        tick(1);
        bus.frame_done_in = 1'b0;
        bus.vcount_in = 10'd0;
        bus.hcount_in = 11'd1100;
        chk({nm, "_swap"}, 12'(bus.swap_out), 12'(sw));
        chk({nm, "_front"}, 12'(bus.front_sel_out), 12'(fr));
        chk({nm, "_clearing"}, 12'(bus.clearing_out), 12'(sw));
        tick(1);
        chk({nm, "_swap_end"}, 12'(bus.swap_out), 12'd0);
    endtask
    task automatic ready_after(input int n, input string nm);
        tick(n - 1);
        chk({nm, "_ready_early"}, 12'(bus.wr_ready_out), 12'd0);
        chk({nm, "_clearing_early"}, 12'(bus.clearing_out), 12'd1);
        tick(1);
        chk({nm, "_ready"}, 12'(bus.wr_ready_out), 12'd1);
        chk({nm, "_clearing_done"}, 12'(bus.clearing_out), 12'd0);
    endtask
    initial begin
        bus.wr_valid_in = 1'b0;
        bus.wr_addr_in = '0;
        bus.wr_color_in = '0;
        bus.frame_done_in = 1'b0;
        bus.hcount_in = 11'd1100;
        bus.vcount_in = 10'd0;
        tick(3);
        chk("rst_pixel", bus.pixel_out, 12'h000);
        chk("rst_swap", 12'(bus.swap_out), 12'd0);
        chk("rst_front", 12'(bus.front_sel_out), 12'd0);
        chk("rst_ready", 12'(bus.wr_ready_out), 12'd0);
        chk("rst_clearing", 12'(bus.clearing_out), 12'd1);
        rst = 1'b0;
        ready_after(8192, "clear_all");
        px(224, 352, 12'h800, "win_color0");
        px(0, 0, 12'h800, "outside_win");
        px(1023, 767, 12'h800, "last_active");
        px(1024, 0, 12'h000, "hblank");
        px(5, 768, 12'h000, "vblank_line");
        wr(0, 10'h3FF);
        wr(1, 10'h080);
        vblank(1'b0, 1'b0, 1'b0, "no_pending");
        px(224, 352, 12'h800, "back_hidden");
        pulse_done();
        chk("ready_after_done", 12'(bus.wr_ready_out), 12'd0);
        bus.wr_valid_in = 1'b1;
        bus.wr_addr_in = 12'd3;
        bus.wr_color_in = 10'h3FF;
        tick(3);
        bus.wr_valid_in = 1'b0;
        vblank(1'b0, 1'b1, 1'b1, "swap1");
        ready_after(4095, "clear1");
        px(224, 352, 12'hEFE, "px_origin");
        px(225, 353, 12'hEFE, "px_origin_dup");
        px(226, 352, 12'h200, "px_x1");
        px(227, 353, 12'h200, "px_x1_dup");
        px(228, 352, 12'h800, "px_x2_zero");
        px(230, 352, 12'h800, "dropped_write");
        px(352, 352, 12'h800, "right_edge");
        px(224, 480, 12'h800, "bottom_edge");
        px(352, 480, 12'h800, "outside_corner");
        px(223, 352, 12'h800, "left_edge");
        wr(0, 10'h155);
        vblank(1'b1, 1'b1, 1'b0, "swap_on_vbs");
        ready_after(4095, "clear2");
        px(224, 352, 12'h4AA, "bank0_c155");
        px(226, 352, 12'h800, "bank0_cleared");
        pulse_done();
        vblank(1'b0, 1'b1, 1'b1, "swap3");
        px(224, 352, 12'h800, "bank1_cleared_a");
        px(226, 352, 12'h800, "bank1_cleared_b");
        tick(95);
        pulse_done();
        rst = 1'b1;
        tick(1);
        chk("midrst_front", 12'(bus.front_sel_out), 12'd0);
        chk("midrst_clearing", 12'(bus.clearing_out), 12'd1);
        chk("midrst_ready", 12'(bus.wr_ready_out), 12'd0);
        chk("midrst_swap", 12'(bus.swap_out), 12'd0);
        rst = 1'b0;
        ready_after(8192, "reclear_all");
        vblank(1'b0, 1'b0, 1'b0, "pending_dropped");
        tick(3);
        chk("queue_drained", 12'(q.size()), 12'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
